// File: rtl/lock_reg_programmer.sv
// Sequencer that writes a bank of NUM_REGS config values, then pulses Lock; it also locks fail-safe on any error.
// Define READBACK_VERIFY_EN to read back and compare each register after it is written.
module lock_reg_programmer #(
  parameter int unsigned NUM_REGS = 4,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned SEL_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                       Clk,
  input  logic                       resetn,
  input  logic                       start,
  input  logic [NUM_REGS*DATA_W-1:0] cfg_data,
  input  logic                       scan_mode,
  input  logic                       debug_unlocked,
  input  logic [DATA_W-1:0]          rd_data,
  output logic [SEL_W-1:0]           wr_sel,
  output logic [DATA_W-1:0]          wr_data,
  output logic                       write,
  output logic                       Lock,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [1:0]                 err_code
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
`ifdef READBACK_VERIFY_EN
    S_VERIFY,
`endif
    S_LOCK,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_REGS - 1);

  state_t              state_q, state_d;
  logic [SEL_W-1:0]    idx_q, idx_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                write_q, write_d;
  logic                lock_q, lock_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [1:0]          err_code_q, err_code_d;

  logic [DATA_W-1:0]   cfg_word [NUM_REGS];
  logic                override;
  logic                go_err;
  logic [1:0]          go_err_code;

  always_comb begin
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      cfg_word[i] = cfg_data[i*DATA_W +: DATA_W];
    end
  end

`ifndef READBACK_VERIFY_EN
  logic unused_rd;
  assign unused_rd = ^rd_data;
`endif

  assign override = scan_mode | debug_unlocked;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    wr_data_d   = wr_data_q;
    write_d     = 1'b0;
    lock_d      = 1'b0;
    busy_d      = busy_q;
    done_d      = done_q;
    err_d       = err_q;
    err_code_d  = err_code_q;
    go_err      = 1'b0;
    go_err_code = 2'd0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (override) begin
            go_err      = 1'b1;
            go_err_code = 2'd2;
          end else begin
            state_d   = S_WRITE;
            idx_d     = '0;
            write_d   = 1'b1;
            wr_data_d = cfg_word[0];
            busy_d    = 1'b1;
          end
        end
      end
      S_WRITE: begin
        if (override) begin
          go_err      = 1'b1;
          go_err_code = 2'd2;
        end else begin
`ifdef READBACK_VERIFY_EN
          state_d = S_VERIFY;
`else
          if (idx_q == LAST_IDX) begin
            state_d = S_LOCK;
            lock_d  = 1'b1;
          end else begin
            idx_d     = idx_q + 1'b1;
            write_d   = 1'b1;
            wr_data_d = cfg_word[idx_q + 1'b1];
          end
`endif
        end
      end
`ifdef READBACK_VERIFY_EN
      S_VERIFY: begin
        // Override outranks a readback mismatch seen in the same cycle.
        if (override) begin
          go_err      = 1'b1;
          go_err_code = 2'd2;
        end else if (rd_data != wr_data_q) begin
          go_err      = 1'b1;
          go_err_code = 2'd1;
        end else if (idx_q == LAST_IDX) begin
          state_d = S_LOCK;
          lock_d  = 1'b1;
        end else begin
          state_d   = S_WRITE;
          idx_d     = idx_q + 1'b1;
          write_d   = 1'b1;
          wr_data_d = cfg_word[idx_q + 1'b1];
        end
      end
`endif
      S_LOCK: begin
        if (override) begin
          go_err      = 1'b1;
          go_err_code = 2'd2;
        end else begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      S_DONE, S_ERROR: ;
      default: state_d = S_IDLE;
    endcase

    // Error entry registers the fail-safe Lock pulse together with the sticky flags.
    if (go_err) begin
      state_d    = S_ERROR;
      write_d    = 1'b0;
      lock_d     = 1'b1;
      busy_d     = 1'b0;
      err_d      = 1'b1;
      err_code_d = go_err_code;
    end
  end

  always_ff @(posedge Clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      wr_data_q  <= '0;
      write_q    <= 1'b0;
      lock_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      wr_data_q  <= wr_data_d;
      write_q    <= write_d;
      lock_q     <= lock_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  assign wr_sel   = idx_q;
  assign wr_data  = wr_data_q;
  assign write    = write_q;
  assign Lock     = lock_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign err_code = err_code_q;

endmodule

// File: tb/tb_lock_reg_programmer.sv
// Directed bench for lock_reg_programmer (NUM_REGS=4, DATA_W=16) with a simple bank model.
module tb_lock_reg_programmer;
  localparam int unsigned N  = 4;
  localparam int unsigned DW = 16;
  localparam int unsigned SW = 2;
`ifdef READBACK_VERIFY_EN
  localparam bit VER = 1'b1;
`else
  localparam bit VER = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic          scan_mode = 1'b0;
  logic          debug_unlocked = 1'b0;
  logic [N*DW-1:0] cfg_data;
  logic [DW-1:0] rd_data, wr_data;
  logic [SW-1:0] wr_sel;
  logic          write, lock, busy, done, err;
  logic [1:0]    err_code;

  logic [DW-1:0] bank [N];
  logic          corrupt = 1'b0;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  int            wr_cnt, lock_cnt, lock_cyc, done_cyc;
  logic          busy1;
  logic [SW-1:0] sel_log  [16];
  logic [DW-1:0] data_log [16];
  int            cyc_log  [16];
  logic [DW-1:0] exp_val  [N];

  lock_reg_programmer #(.NUM_REGS(N), .DATA_W(DW)) dut (
    .Clk(clk), .resetn(resetn), .start(start), .cfg_data(cfg_data),
    .scan_mode(scan_mode), .debug_unlocked(debug_unlocked), .rd_data(rd_data),
    .wr_sel(wr_sel), .wr_data(wr_data), .write(write), .Lock(lock),
    .busy(busy), .done(done), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (write) bank[wr_sel] <= wr_data;
  always_comb rd_data = (corrupt && wr_sel == 2'd2) ? 16'h3332 : bank[wr_sel];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    resetn = 1'b0;
    scan_mode = 1'b0;
    debug_unlocked = 1'b0;
    corrupt = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  // Pulse start (edge T0 is cycle 0), then log outputs for cycles T0+1..T0+budget.
  task automatic run_seq(input int budget, input int scan_at);
    wr_cnt = 0; lock_cnt = 0; lock_cyc = 0; done_cyc = 0; busy1 = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (c == 1) busy1 = busy;
      if (write) begin
        if (wr_cnt < 16) begin
          sel_log[wr_cnt] = wr_sel; data_log[wr_cnt] = wr_data; cyc_log[wr_cnt] = c;
        end
        wr_cnt++;
      end
      if (lock) begin
        if (lock_cnt == 0) lock_cyc = c;
        lock_cnt++;
      end
      if (done && done_cyc == 0) done_cyc = c;
      if (c == scan_at) scan_mode = 1'b1;
    end
  endtask

  task automatic check_clean(input string pfx);
    check({pfx, "_wr_cnt"}, wr_cnt, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_sel%0d", pfx, i), sel_log[i], i);
      check($sformatf("%s_data%0d", pfx, i), data_log[i], exp_val[i]);
      check($sformatf("%s_wcyc%0d", pfx, i), cyc_log[i], VER ? 2*i+1 : i+1);
    end
    check({pfx, "_busy1"}, busy1, 1);
    check({pfx, "_lock_cnt"}, lock_cnt, 1);
    check({pfx, "_lock_cyc"}, lock_cyc, VER ? 9 : 5);
    check({pfx, "_done_cyc"}, done_cyc, VER ? 10 : 6);
    check({pfx, "_err"}, err, 0);
    check({pfx, "_busy_end"}, busy, 0);
    for (int i = 0; i < 4; i++) check($sformatf("%s_bank%0d", pfx, i), bank[i], exp_val[i]);
  endtask

  initial begin
    exp_val[0] = 16'h1111; exp_val[1] = 16'h2222; exp_val[2] = 16'h3333; exp_val[3] = 16'hABCD;
    cfg_data = {16'hABCD, 16'h3333, 16'h2222, 16'h1111};
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("rst_write", write, 0);
    check("rst_lock", lock, 0);
    check("rst_sel", wr_sel, 0);
    check("rst_data", wr_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_code", err_code, 0);

    run_seq(14, 0);
    check_clean("clean");
    check("clean_done", done, 1);

    run_seq(6, 0);
    check("done_restart_wr", wr_cnt, 0);
    check("done_restart_lock", lock_cnt, 0);
    check("done_restart_done", done, 1);
    check("done_restart_err", err, 0);

    reset_dut();
    corrupt = 1'b1;
    run_seq(14, 0);
    if (VER) begin
      check("mm_wr_cnt", wr_cnt, 3);
      check("mm_lock_cnt", lock_cnt, 1);
      check("mm_lock_cyc", lock_cyc, 7);
      check("mm_err", err, 1);
      check("mm_code", err_code, 1);
      check("mm_done", done, 0);
    end else begin
      check("nv_wr_cnt", wr_cnt, 4);
      check("nv_done", done, 1);
      check("nv_code", err_code, 0);
    end

    reset_dut();
    debug_unlocked = 1'b1;
    run_seq(6, 0);
    check("dbg_wr_cnt", wr_cnt, 0);
    check("dbg_lock_cyc", lock_cyc, 1);
    check("dbg_lock_cnt", lock_cnt, 1);
    check("dbg_err", err, 1);
    check("dbg_code", err_code, 2);
    check("dbg_busy1", busy1, 0);

    debug_unlocked = 1'b0;
    run_seq(6, 0);
    check("err_restart_wr", wr_cnt, 0);
    check("err_restart_lock", lock_cnt, 0);
    check("err_restart_err", err, 1);
    check("err_restart_code", err_code, 2);

    reset_dut();
    run_seq(12, VER ? 3 : 2);
    check("scan_wr_cnt", wr_cnt, 2);
    check("scan_lock_cnt", lock_cnt, 1);
    check("scan_lock_cyc", lock_cyc, VER ? 4 : 3);
    check("scan_code", err_code, 2);
    check("scan_done", done, 0);
    check("scan_bank1", bank[1], 16'h2222);

    reset_dut();
    run_seq(3, 0);
    resetn = 1'b0;
    #1;
    check("mid_rst_write", write, 0);
    check("mid_rst_lock", lock, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_sel", wr_sel, 0);
    check("mid_rst_data", wr_data, 0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    run_seq(14, 0);
    check_clean("after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
